// File: rtl/pixel_dispatcher_if.sv
// Job bus between the pixel dispatcher and up to four ray-tracing cores.
// Handshake: core_start_k is a one-cycle valid for core k, and core_ready_k is that
// core's ready. A job transfers on the edge where core_start_k is high, and the core
// must drop core_ready_k on that same edge. job_x/job_y/job_eol/job_eof are shared
// and meaningful only while some core_start_k is high.
interface pixel_dispatcher_if #(
   parameter int X_W = 11,
   parameter int Y_W = 10
);
   logic           core_ready_1;
   logic           core_ready_2;
   logic           core_ready_3;
   logic           core_ready_4;
   logic           core_start_1;
   logic           core_start_2;
   logic           core_start_3;
   logic           core_start_4;
   logic [X_W-1:0] job_x;
   logic [Y_W-1:0] job_y;
   logic           job_eol;
   logic           job_eof;

   modport master (
      input  core_ready_1, core_ready_2, core_ready_3, core_ready_4,
      output core_start_1, core_start_2, core_start_3, core_start_4,
      output job_x, job_y, job_eol, job_eof
   );

   modport slave (
      output core_ready_1, core_ready_2, core_ready_3, core_ready_4,
      input  core_start_1, core_start_2, core_start_3, core_start_4,
      input  job_x, job_y, job_eol, job_eof
   );
endinterface

// File: rtl/pixel_dispatcher.sv
// Raster-order pixel job dispatcher feeding up to four cores in strict round-robin.
// Optional macro PIXEL_DISPATCH_STALL_CNT_EN adds a saturating stall_cycles counter.
module pixel_dispatcher #(
   parameter int MAX_CORES = 4,
   parameter int X_W       = 11,
   parameter int Y_W       = 10
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  start,
   input  logic [X_W-1:0]        frame_w,
   input  logic [Y_W-1:0]        frame_h,
   input  logic [2:0]            no_of_extra_cores,
   pixel_dispatcher_if.master    cores,
   output logic                  busy,
   output logic                  frame_done,
`ifdef PIXEL_DISPATCH_STALL_CNT_EN
   output logic [31:0]           stall_cycles,
`endif
   output logic [1:0]            state_dbg
);

   localparam int IDX_W = $clog2(MAX_CORES);
   localparam logic [X_W-1:0]   X_ONE   = X_W'(1);
   localparam logic [Y_W-1:0]   Y_ONE   = Y_W'(1);
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAX_CORES - 1);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_READY = 2'd1,
      ISSUE      = 2'd2,
      DONE       = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [X_W-1:0]     fw_q, x_q, job_x_q;
   logic [Y_W-1:0]     fh_q, y_q, job_y_q;
   logic [IDX_W-1:0]   extra_q, idx_q, extra_c;
   logic [MAX_CORES-1:0] ready_vec, start_d, start_q;
   logic               ready_sel, eol_now, eof_now;
   logic               job_eol_q, job_eof_q;

   assign ready_vec = {cores.core_ready_4, cores.core_ready_3,
                       cores.core_ready_2, cores.core_ready_1};
   // Only the core whose turn it is matters; cores above extra are never selected.
   assign ready_sel = ready_vec[idx_q];
   assign eol_now   = (x_q == fw_q - X_ONE);
   assign eof_now   = eol_now && (y_q == fh_q - Y_ONE);
   assign extra_c   = (no_of_extra_cores > 3'(MAX_CORES - 1)) ? IDX_MAX
                                                               : no_of_extra_cores[IDX_W-1:0];

   always_comb begin
      state_d = state_q;
      start_d = '0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = (frame_w == '0 || frame_h == '0) ? DONE : WAIT_READY;
            end
         end
         WAIT_READY: begin
            if (ready_sel) begin
               state_d        = ISSUE;
               start_d[idx_q] = 1'b1;
            end
         end
         ISSUE:   state_d = eof_now ? DONE : WAIT_READY;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q    <= IDLE;
         fw_q       <= '0;
         fh_q       <= '0;
         extra_q    <= '0;
         x_q        <= '0;
         y_q        <= '0;
         idx_q      <= '0;
         start_q    <= '0;
         job_x_q    <= '0;
         job_y_q    <= '0;
         job_eol_q  <= 1'b0;
         job_eof_q  <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (start) begin
                  fw_q    <= frame_w;
                  fh_q    <= frame_h;
                  extra_q <= extra_c;
                  x_q     <= '0;
                  y_q     <= '0;
                  idx_q   <= '0;
               end
            end
            ISSUE: begin
               // Core index wraps on its own, independent of line boundaries.
               if (eol_now) begin
                  x_q <= '0;
                  y_q <= eof_now ? '0 : y_q + Y_ONE;
               end else begin
                  x_q <= x_q + X_ONE;
               end
               idx_q <= (idx_q == extra_q) ? '0 : idx_q + IDX_ONE;
            end
            default: ;
         endcase
         // Outputs are registered from the next state so they line up with it.
         busy       <= (state_d != IDLE);
         frame_done <= (state_d == DONE);
         start_q    <= start_d;
         if (state_d == ISSUE) begin
            job_x_q   <= x_q;
            job_y_q   <= y_q;
            job_eol_q <= eol_now;
            job_eof_q <= eof_now;
         end
      end
   end

`ifdef PIXEL_DISPATCH_STALL_CNT_EN
   always_ff @(posedge aclk) begin
      if (areset) begin
         stall_cycles <= '0;
      end else if (state_q == IDLE && start) begin
         stall_cycles <= '0;
      end else if (state_q == WAIT_READY && !ready_sel && stall_cycles != '1) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

   assign cores.core_start_1 = start_q[0];
   assign cores.core_start_2 = start_q[1];
   assign cores.core_start_3 = start_q[2];
   assign cores.core_start_4 = start_q[3];
   assign cores.job_x        = job_x_q;
   assign cores.job_y        = job_y_q;
   assign cores.job_eol      = job_eol_q;
   assign cores.job_eof      = job_eof_q;
   assign state_dbg          = state_q;

endmodule
